uart_image_loader: RTL and testbench
====================================

Name: uart_image_loader

Overview:
- Upstream stage of the VGA image/TFHE display path: receives a raw 8-bit grayscale image over a UART 8N1 link and writes it byte-by-byte into the image buffer's write port.
- Replaces the static $readmemh image with a runtime-loadable frame.
- On completion, raises `done`. The consumer (the image processing/display controller) may then start its PROCESS pass.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate. DIV = CLK_HZ/BAUD is integer-truncated and must be >= 8.
- IMG_BYTES, 4096, number of pixel bytes per frame (64x64).
- ADDR_W, 12, width of wr_addr. Requires 2^ADDR_W >= IMG_BYTES.
- TIMEOUT_CYC, 1000000, maximum number of idle clk cycles allowed between bytes once a frame has started.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rx  in  1  UART serial input, idle high, asynchronous to clk.
- start  in  1  single-cycle pulse; arms the loader for a new frame.
- wr_en  out  1  write strobe to the image buffer, one cycle per pixel.
- wr_addr  out  ADDR_W  pixel address, 0..IMG_BYTES-1.
- wr_data  out  8  pixel byte.
- busy  out  1  high while armed or receiving.
- done  out  1  sticky; frame fully written. Cleared by start or reset.
- err_frame  out  1  sticky; a stop bit was sampled low. Cleared by start.
- err_timeout  out  1  sticky; inter-byte timeout hit. Cleared by start.
- err_checksum  out  1  sticky; checksum mismatch. Tied 0 when CHECKSUM_EN is not defined.

Behaviour:
- Reset values: wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, all err_*=0. FSM goes to IDLE; baud, bit and timeout counters go to 0.
- rx passes through a 2-flop synchronizer, reset value 1. All decisions use the synchronized value.
- FSM states: IDLE, ARMED, START, DATA, STOP, WRITE, (CHECK), DONE.
- IDLE:
  - on start=1: clear done and all err_*, set wr_addr=0, go to ARMED, busy=1.
- ARMED:
  - wait for falling edge of rx (synchronized 1->0), then go to START.
  - the timeout counter runs only after the first byte has been received; ARMED waits forever before the first byte.
- START:
  - count DIV/2 cycles, then resample rx.
  - if rx=1, treat as a glitch and return to ARMED.
  - if rx=0, go to DATA.
- DATA:
  - sample 8 bits, LSB first, each DIV cycles after the previous sample (mid-bit).
- STOP:
  - sample after DIV cycles.
  - if rx=1, go to WRITE.
  - if rx=0, set err_frame, discard the byte, do not advance wr_addr, and return to ARMED.
- WRITE:
  - pulse wr_en=1 for exactly 1 cycle, with wr_data=byte and wr_addr=current address.
  - latency: the wr_en cycle is the cycle after the stop-bit sample.
  - if wr_addr == IMG_BYTES-1: go to DONE (or CHECK when CHECKSUM_EN). wr_addr holds its value.
  - otherwise: wr_addr+1, return to ARMED.
- DONE:
  - done=1, busy=0.
  - ignore rx.
  - start=1 re-arms, with the same effect as start in IDLE.
- Timeout:
  - counter clears on every received byte and counts every cycle in ARMED after the first byte.
  - on reaching TIMEOUT_CYC: set err_timeout, busy=0, go to IDLE. done stays 0.
- start asserted in ARMED/START/DATA/STOP/WRITE: ignored.
- Reset mid-frame: immediate abort, all outputs return to reset values. The consumer must treat buffer contents as invalid until done.
- wr_addr never exceeds IMG_BYTES-1. Extra bytes arriving after DONE are never written.

Optional Feature:
- Macro: UART_IMAGE_LOADER_CHECKSUM_EN.
- Defined:
  - after the last pixel the FSM enters CHECK and receives one more UART byte (same START/DATA/STOP path, no wr_en).
  - an 8-bit running sum covers all pixel bytes plus this byte.
  - sum == 0 mod 256: done=1.
  - otherwise: err_checksum=1, done=0, go to IDLE.
  - timeout and frame-error rules still apply to the checksum byte.
- Not defined:
  - no CHECK state; done is set directly after the last write; err_checksum is held 0.

Test Plan (sim params: CLK_HZ=1600000, BAUD=100000 so DIV=16; IMG_BYTES=4; ADDR_W=2; TIMEOUT_CYC=400):
- Reset, then start pulse, then send bytes 0x12,0x34,0x56,0x78 -> four wr_en pulses at addr 0..3 with matching data, each 1 cycle after the stop-bit sample; done=1, busy=0, no err_*.
- Send 0xA5 with stop bit forced 0, then 0xA5 normally -> err_frame=1; only one wr_en, at addr 0 with data 0xA5.
- rx low glitch of 4 cycles while ARMED -> no wr_en; FSM back in ARMED; next byte 0x3C is written at addr 0.
- Send 2 bytes, then hold rx high for 400 cycles -> err_timeout=1, busy=0, done=0; a new start clears err_timeout.
- Assert rst_n=0 during DATA of the 3rd byte -> all outputs 0 immediately; after release and a new start, the next byte is written at addr 0.
- CHECKSUM_EN defined: send 0x01,0x02,0x03,0x04 then 0xF6 -> done=1. Repeat with 0xF7 -> err_checksum=1, done=0.

Source files
------------

// File: rtl/uart_image_loader.sv
// Receives a raw 8-bit grayscale frame over UART 8N1 and streams it into the image buffer write port.
// Optional trailing checksum byte: define UART_IMAGE_LOADER_CHECKSUM_EN.
module uart_image_loader #(
    parameter int CLK_HZ      = 100000000,
    parameter int BAUD        = 115200,
    parameter int IMG_BYTES   = 4096,
    parameter int ADDR_W      = 12,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    input  logic              start,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic              err_frame,
    output logic              err_timeout,
    output logic              err_checksum
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int CNT_W = $clog2(DIV);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(DIV - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(IMG_BYTES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARMED = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_WRITE = 3'd5;
`ifdef UART_IMAGE_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHECK = 3'd6;
`endif
    localparam logic [2:0] S_DONE  = 3'd7;

    logic [2:0]       state;
    logic [2:0]       wait_state;
    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    logic             rx_fall;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic [TMO_W-1:0] tmo_cnt;
    logic             got_byte;

`ifdef UART_IMAGE_LOADER_CHECKSUM_EN
    logic       in_check;
    logic [7:0] sum;
    logic [7:0] chk_total;
    logic       err_chk;

    assign wait_state   = in_check ? S_CHECK : S_ARMED;
    assign chk_total    = sum + shift;
    assign err_checksum = err_chk;
`else
    assign wait_state   = S_ARMED;
    assign err_checksum = 1'b0;
`endif

    assign busy    = (state != S_IDLE) && (state != S_DONE);
    assign done    = (state == S_DONE);
    assign rx_fall = rx_prev && !rx_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            tmo_cnt     <= '0;
            got_byte    <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            err_frame   <= 1'b0;
            err_timeout <= 1'b0;
`ifdef UART_IMAGE_LOADER_CHECKSUM_EN
            in_check    <= 1'b0;
            sum         <= '0;
            err_chk     <= 1'b0;
`endif
        end else begin
            wr_en <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state       <= S_ARMED;
                        wr_addr     <= '0;
                        err_frame   <= 1'b0;
                        err_timeout <= 1'b0;
                        got_byte    <= 1'b0;
                        tmo_cnt     <= '0;
`ifdef UART_IMAGE_LOADER_CHECKSUM_EN
                        in_check    <= 1'b0;
                        sum         <= '0;
                        err_chk     <= 1'b0;
`endif
                    end
                end

`ifdef UART_IMAGE_LOADER_CHECKSUM_EN
                S_ARMED, S_CHECK: begin
`else
                S_ARMED: begin
`endif
                    // The idle timer only runs once the frame has delivered its first byte.
                    if (got_byte && tmo_cnt == TMO_LAST) begin
                        err_timeout <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        if (got_byte) begin
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                        end
                        if (rx_fall) begin
                            state    <= S_START;
                            baud_cnt <= '0;
                        end
                    end
                end

                S_START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= rx_sync ? wait_state : S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                S_DATA: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        shift    <= {rx_sync, shift[7:1]};
                        if (bit_cnt == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                S_STOP: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        if (!rx_sync) begin
                            err_frame <= 1'b1;
                            state     <= wait_state;
`ifdef UART_IMAGE_LOADER_CHECKSUM_EN
                        end else if (in_check) begin
                            if (chk_total == 8'd0) begin
                                state <= S_DONE;
                            end else begin
                                err_chk <= 1'b1;
                                state   <= S_IDLE;
                            end
`endif
                        end else begin
                            wr_en   <= 1'b1;
                            wr_data <= shift;
                            state   <= S_WRITE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                S_WRITE: begin
                    got_byte <= 1'b1;
                    tmo_cnt  <= '0;
`ifdef UART_IMAGE_LOADER_CHECKSUM_EN
                    sum      <= sum + wr_data;
`endif
                    if (wr_addr == ADDR_LAST) begin
`ifdef UART_IMAGE_LOADER_CHECKSUM_EN
                        in_check <= 1'b1;
                        state    <= S_CHECK;
`else
                        state    <= S_DONE;
`endif
                    end else begin
                        wr_addr <= wr_addr + ADDR_W'(1);
                        state   <= S_ARMED;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_image_loader.sv
// Directed bench for uart_image_loader: frame-level model of expected writes and status flags,
// checked every cycle, plus literal expectations. Honours UART_IMAGE_LOADER_CHECKSUM_EN.
module tb_uart_image_loader;

    localparam int CLK_HZ      = 1600000;
    localparam int BAUD        = 100000;
    localparam int DIV         = CLK_HZ / BAUD;
    localparam int IMG_BYTES   = 4;
    localparam int ADDR_W      = 2;
    localparam int TIMEOUT_CYC = 400;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rx = 1'b1;
    logic              start = 1'b0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              busy;
    logic              done;
    logic              err_frame;
    logic              err_timeout;
    logic              err_checksum;

    uart_image_loader #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .IMG_BYTES(IMG_BYTES),
        .ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .start(start),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err_frame(err_frame),
        .err_timeout(err_timeout), .err_checksum(err_checksum)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int stop_start = 0;

    // Frame-level model state
    int exp_addr[$];
    int exp_data[$];
    int wlog_addr[$];
    int wlog_data[$];
    int m_addr = 0;
    int m_sum = 0;
    bit m_active = 0;
    bit flags_vld = 0;
    bit exp_busy = 0, exp_done = 0, exp_ef = 0, exp_et = 0, exp_ec = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            if (n_errors <= 30) $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en) begin
            wlog_addr.push_back(int'(wr_addr));
            wlog_data.push_back(int'(wr_data));
            check("wr_en_expected", int'(exp_addr.size() > 0), 1);
            if (exp_addr.size() > 0) begin
                check("wr_addr", int'(wr_addr), exp_addr.pop_front());
                check("wr_data", int'(wr_data), exp_data.pop_front());
                check("wr_in_stop_bit", int'((cyc - stop_start) >= DIV / 2 && (cyc - stop_start) <= DIV), 1);
            end
        end
        if (flags_vld) begin
            check("busy", int'(busy), int'(exp_busy));
            check("done", int'(done), int'(exp_done));
            check("err_frame", int'(err_frame), int'(exp_ef));
            check("err_timeout", int'(err_timeout), int'(exp_et));
            check("err_checksum", int'(err_checksum), int'(exp_ec));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic gap();
        tick(2 * DIV);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(DIV);
        end
        rx = stop_bit;
        stop_start = cyc;
        tick(DIV);
        rx = 1'b1;
    endtask

    task automatic pulse_start();
        flags_vld = 0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
        if (!m_active) begin
            m_active = 1; m_addr = 0; m_sum = 0;
            exp_busy = 1; exp_done = 0; exp_ef = 0; exp_et = 0; exp_ec = 0;
        end
        flags_vld = 1;
    endtask

    task automatic pixel(input logic [7:0] d);
        bit last;
        last = (m_addr == IMG_BYTES - 1);
        exp_addr.push_back(m_addr);
        exp_data.push_back(int'(d));
        m_sum = m_sum + int'(d);
`ifndef UART_IMAGE_LOADER_CHECKSUM_EN
        if (last) flags_vld = 0;
`endif
        send_byte(d, 1'b1);
        gap();
`ifndef UART_IMAGE_LOADER_CHECKSUM_EN
        if (last) begin
            exp_done = 1; exp_busy = 0; m_active = 0;
            flags_vld = 1;
        end
`endif
        if (!last) m_addr++;
    endtask

    task automatic bad_byte(input logic [7:0] d);
        flags_vld = 0;
        send_byte(d, 1'b0);
        gap();
        exp_ef = 1;
        flags_vld = 1;
    endtask

`ifdef UART_IMAGE_LOADER_CHECKSUM_EN
    task automatic chk_byte(input logic [7:0] d);
        flags_vld = 0;
        send_byte(d, 1'b1);
        gap();
        if (((m_sum + int'(d)) % 256) == 0) exp_done = 1;
        else exp_ec = 1;
        exp_busy = 0;
        m_active = 0;
        flags_vld = 1;
    endtask

    task automatic good_chk();
        chk_byte(8'((256 - (m_sum % 256)) % 256));
    endtask
`endif

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"}, int'(wr_en), 0);
        check({tag, "_wr_addr"}, int'(wr_addr), 0);
        check({tag, "_wr_data"}, int'(wr_data), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_err_frame"}, int'(err_frame), 0);
        check({tag, "_err_timeout"}, int'(err_timeout), 0);
        check({tag, "_err_checksum"}, int'(err_checksum), 0);
    endtask

    initial begin
        int n0;
        // Reset state
        rst_n = 1'b0;
        tick(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        tick(2);
        flags_vld = 1;

        // Full frame
        pulse_start();
        check("armed_busy", int'(busy), 1);
        pixel(8'h12);
        pixel(8'h34);
        pixel(8'h56);
        pixel(8'h78);
`ifdef UART_IMAGE_LOADER_CHECKSUM_EN
        good_chk();
`endif
        check("frame1_writes", wlog_addr.size(), 4);
        if (wlog_addr.size() >= 4) begin
            check("frame1_w0_data", wlog_data[0], 'h12);
            check("frame1_w3_addr", wlog_addr[3], 3);
            check("frame1_w3_data", wlog_data[3], 'h78);
        end
        check("frame1_done", int'(done), 1);
        check("frame1_busy", int'(busy), 0);
        check("frame1_addr_hold", int'(wr_addr), 3);

        // Extra byte after completion must not be written
        send_byte(8'h99, 1'b1);
        gap();
        check("post_done_no_write", wlog_addr.size(), 4);

        // Frame error, then a good byte, then a second byte and idle until timeout
        pulse_start();
        check("restart_done_clear", int'(done), 0);
        n0 = wlog_addr.size();
        bad_byte(8'hA5);
        check("frame_err_flag", int'(err_frame), 1);
        pixel(8'hA5);
        check("frame_err_one_write", wlog_addr.size(), n0 + 1);
        if (wlog_addr.size() > n0) begin
            check("frame_err_w_addr", wlog_addr[n0], 0);
            check("frame_err_w_data", wlog_data[n0], 'hA5);
        end
        pixel(8'h5A);
        tick(340);
        check("timeout_not_yet", int'(err_timeout), 0);
        check("timeout_not_yet_busy", int'(busy), 1);
        flags_vld = 0;
        tick(60);
        exp_et = 1; exp_busy = 0; m_active = 0;
        flags_vld = 1;
        check("timeout_flag", int'(err_timeout), 1);
        check("timeout_done", int'(done), 0);
        pulse_start();
        check("timeout_cleared", int'(err_timeout), 0);

        // Start-bit glitch while armed
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(40);
        n0 = wlog_addr.size();
        check("glitch_no_write", n0, wlog_addr.size());
        pixel(8'h3C);
        if (wlog_addr.size() > n0) begin
            check("glitch_w_addr", wlog_addr[n0], 0);
            check("glitch_w_data", wlog_data[n0], 'h3C);
        end
        pixel(8'h01);
        pixel(8'h02);
        pixel(8'h03);
`ifdef UART_IMAGE_LOADER_CHECKSUM_EN
        good_chk();
`endif
        check("glitch_frame_done", int'(done), 1);

        // Reset during the data bits of the third byte
        pulse_start();
        pixel(8'h11);
        pixel(8'h22);
        flags_vld = 0;
        fork
            send_byte(8'h33, 1'b1);
            begin
                tick(40);
                rst_n = 1'b0;
                #1;
                check_all_zero("midreset");
                tick(3);
                rst_n = 1'b1;
            end
        join
        m_active = 0; m_addr = 0; m_sum = 0;
        exp_busy = 0; exp_done = 0; exp_ef = 0; exp_et = 0; exp_ec = 0;
        gap();
        flags_vld = 1;
        pulse_start();
        n0 = wlog_addr.size();
        pixel(8'h44);
        if (wlog_addr.size() > n0) begin
            check("after_reset_w_addr", wlog_addr[n0], 0);
            check("after_reset_w_data", wlog_data[n0], 'h44);
        end
        pixel(8'h55);
        pixel(8'h66);
        pixel(8'h77);
`ifdef UART_IMAGE_LOADER_CHECKSUM_EN
        good_chk();

        // Checksum accept / reject
        pulse_start();
        pixel(8'h01); pixel(8'h02); pixel(8'h03); pixel(8'h04);
        chk_byte(8'hF6);
        check("cksum_ok_done", int'(done), 1);
        check("cksum_ok_err", int'(err_checksum), 0);
        pulse_start();
        pixel(8'h01); pixel(8'h02); pixel(8'h03); pixel(8'h04);
        chk_byte(8'hF7);
        check("cksum_bad_err", int'(err_checksum), 1);
        check("cksum_bad_done", int'(done), 0);
        check("cksum_bad_busy", int'(busy), 0);
`endif
        check("final_done", int'(done), int'(exp_done));
        check("exp_queue_drained", exp_addr.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
